// File: rtl/cc_tracker_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : lc3b_types                                                  |
// | Brief   : LC-3b datapath word / condition-code types shared by cc_*   |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_nzp;

    localparam lc3b_nzp NZP_RESET = 3'b010;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/cc_tracker_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : cc_tracker_if                                               |
// | Brief   : pipeline <-> condition-code tracker signal bundle           |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
interface cc_tracker_if;
    import lc3b_types::*;

    logic     cc_issue;
    logic     cc_wb;
    lc3b_word cc_wb_data;
    logic     flush;
    lc3b_nzp  nzp_cc;
    logic     cc_valid;
    logic     cc_full;
    logic     cc_err;

    // Pipeline control side.
    modport master (
        output cc_issue, cc_wb, cc_wb_data, flush,
        input  nzp_cc, cc_valid, cc_full, cc_err
    );

    // Tracker side.
    modport slave (
        input  cc_issue, cc_wb, cc_wb_data, flush,
        output nzp_cc, cc_valid, cc_full, cc_err
    );

endinterface : cc_tracker_if
`default_nettype wire

// File: rtl/cc_tracker_gencc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : gencc                                                       |
// | Brief   : one-hot {n,z,p} from a 16-bit writeback word                |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module gencc
    import lc3b_types::*;
(
    input  wire lc3b_word i_word,
    output lc3b_nzp       o_nzp
);

    logic w_zero;

    assign w_zero = (i_word == 16'h0000);
    assign o_nzp  = {i_word[15], w_zero, ~i_word[15] & ~w_zero};

endmodule : gencc
`default_nettype wire

// File: rtl/cc_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : cc_tracker                                                  |
// | Brief   : NZP register, in-flight CC-writer counter and WB bypass     |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module cc_tracker
    import lc3b_types::*;
#(
    parameter  int MAX_PENDING = 4,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  wire logic    clk,
    input  wire logic    reset,
    cc_tracker_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_max  = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero = '0;

    lc3b_nzp          r_nzp;
    logic [CNT_W-1:0] r_pending;
    logic             r_err;

    lc3b_nzp          w_wb_nzp;
    logic             w_full;
    logic             w_bypass;

    // Single decoder feeds both the register input and the bypass path.
    gencc u_gencc (
        .i_word (bus.cc_wb_data),
        .o_nzp  (w_wb_nzp)
    );

    assign w_full   = (r_pending == c_max);
    assign w_bypass = (r_pending == c_one) & bus.cc_wb & ~bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nzp     <= NZP_RESET;
            r_pending <= c_zero;
            r_err     <= 1'b0;
        end else begin
            // A writeback in the flush cycle is older than the squash.
            if (bus.cc_wb) begin
                r_nzp <= w_wb_nzp;
            end
            if (bus.flush) begin
                r_pending <= c_zero;
            end else begin
                unique case ({bus.cc_issue, bus.cc_wb})
                    2'b10: begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_pending <= r_pending + c_one;
                        end
                    end
                    2'b01: begin
                        // Untracked writers at zero leave the count alone.
                        if (r_pending != c_zero) begin
                            r_pending <= r_pending - c_one;
                        end
                    end
                    default: begin
                        r_pending <= r_pending;
                    end
                endcase
            end
        end
    end

    assign bus.nzp_cc   = w_bypass ? w_wb_nzp : r_nzp;
    assign bus.cc_valid = w_bypass | (r_pending == c_zero);
    assign bus.cc_full  = w_full;
    assign bus.cc_err   = r_err;

endmodule : cc_tracker
`default_nettype wire
